// File: rtl/sram_controller_pkg.sv
// Shared constants and state encoding for the memory-stage SRAM controller
// that splits each 32-bit access into two 16-bit SRAM transactions.
package sram_controller_pkg;

    localparam int ADDRESS_LEN         = 32;
    localparam int SRAM_DATA_LEN       = 16;
    localparam int DEFAULT_SRAM_AW     = 18;
    localparam int DEFAULT_ADDR_BASE   = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_controller.sv
// Memory-stage responder: serves pipeline loads/stores as two 16-bit SRAM
// halfword accesses (low then high) and holds ready low until the access ends.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDRESS_LEN-1:0]   address,
    input  logic [ADDRESS_LEN-1:0]   writeData,
    output logic [ADDRESS_LEN-1:0]   readData,
    output logic                     ready,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0]       SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N
);

    // WAIT_CYCLES must be at least 2 so each write phase has a WE_N-low cycle
    // followed by a WE_N-high cycle with address and data still held.
    localparam int                CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    sram_state_t              r_state;
    sram_state_t              w_nextState;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_nextCnt;
    logic [SRAM_AW-2:0]       r_word;
    logic [SRAM_AW-2:0]       w_nextWord;
    logic [ADDRESS_LEN-1:0]   r_wdata;
    logic [ADDRESS_LEN-1:0]   w_nextWdata;
    logic                     r_isWrite;
    logic                     w_nextIsWrite;
    logic [ADDRESS_LEN-1:0]   r_readData;
    logic                     r_weN;
    logic                     w_nextWeN;
    logic [SRAM_AW-1:0]       r_sramAddr;
    logic [SRAM_AW-1:0]       w_nextSramAddr;
    logic                     r_dqOe;
    logic                     w_nextDqOe;
    logic [SRAM_DATA_LEN-1:0] r_dqOut;
    logic [SRAM_DATA_LEN-1:0] w_nextDqOut;
    logic                     w_accept;
    logic                     w_nextInPhase;
    logic [ADDRESS_LEN-1:0]   w_offset;
    logic [SRAM_AW-2:0]       w_word;
    logic                     w_unusedOffsetBits;

    // Addresses below ADDR_BASE simply wrap through the truncation.
    assign w_offset           = address - ADDRESS_LEN'(ADDR_BASE);
    assign w_word             = w_offset[SRAM_AW:2];
    assign w_unusedOffsetBits = ^{w_offset[ADDRESS_LEN-1:SRAM_AW+1], w_offset[1:0]};

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    w_nextState = ST_LOW;
                    w_nextCnt   = '0;
                    w_accept    = 1'b1;
                end
            end
            ST_LOW: begin
                if (r_cnt == CNT_LAST) begin
                    w_nextState = ST_HIGH;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (r_cnt == CNT_LAST) begin
                    w_nextState = ST_DONE;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextCnt   = '0;
            end
        endcase

        w_nextIsWrite = w_accept ? wr_en     : r_isWrite;
        w_nextWord    = w_accept ? w_word    : r_word;
        w_nextWdata   = w_accept ? writeData : r_wdata;
        w_nextInPhase = (w_nextState == ST_LOW) || (w_nextState == ST_HIGH);

        // SRAM pins are registered from the next state so WE_N never glitches.
        w_nextWeN      = ~(w_nextIsWrite && w_nextInPhase && (w_nextCnt != CNT_LAST));
        w_nextDqOe     = w_nextIsWrite && w_nextInPhase;
        w_nextDqOut    = (w_nextState == ST_HIGH) ? w_nextWdata[31:16] : w_nextWdata[15:0];
        w_nextSramAddr = r_sramAddr;
        if (w_nextState == ST_LOW) begin
            w_nextSramAddr = {w_nextWord, 1'b0};
        end else if (w_nextState == ST_HIGH) begin
            w_nextSramAddr = {w_nextWord, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_isWrite  <= 1'b0;
            r_readData <= '0;
            r_weN      <= 1'b1;
            r_sramAddr <= '0;
            r_dqOe     <= 1'b0;
            r_dqOut    <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_nextCnt;
            r_word     <= w_nextWord;
            r_wdata    <= w_nextWdata;
            r_isWrite  <= w_nextIsWrite;
            r_weN      <= w_nextWeN;
            r_sramAddr <= w_nextSramAddr;
            r_dqOe     <= w_nextDqOe;
            r_dqOut    <= w_nextDqOut;
            if (!r_isWrite && (r_cnt == CNT_LAST)) begin
                if (r_state == ST_LOW) begin
                    r_readData[15:0] <= SRAM_DQ;
                end else if (r_state == ST_HIGH) begin
                    r_readData[31:16] <= SRAM_DQ;
                end
            end
        end
    end

    assign ready     = ((r_state == ST_IDLE) && !rd_en && !wr_en) || (r_state == ST_DONE);
    assign readData  = r_readData;
    assign SRAM_DQ   = r_dqOe ? r_dqOut : {SRAM_DATA_LEN{1'bz}};
    assign SRAM_ADDR = r_sramAddr;
    assign SRAM_WE_N = r_weN;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with an inline 256K x 16
// asynchronous-read SRAM model that writes on the rising edge of WE_N.
module tb_sram_controller;

    logic        clk;
    logic        rstN;
    logic        wrEn;
    logic        rdEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] sramDq;
    logic [17:0] sramAddr;
    logic        sramWeN;
    logic        sramUbN;
    logic        sramLbN;
    logic        sramCeN;
    logic        sramOeN;
    logic        modelOe;
    logic [15:0] sramMem [0:262143];
    int          checkCount;
    int          errorCount;

    sram_controller #(
        .ADDR_BASE   (1024),
        .WAIT_CYCLES (2),
        .SRAM_AW     (18)
    ) dut (
        .clk       (clk),
        .rst       (rstN),
        .wr_en     (wrEn),
        .rd_en     (rdEn),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .ready     (ready),
        .SRAM_DQ   (sramDq),
        .SRAM_ADDR (sramAddr),
        .SRAM_WE_N (sramWeN),
        .SRAM_UB_N (sramUbN),
        .SRAM_LB_N (sramLbN),
        .SRAM_CE_N (sramCeN),
        .SRAM_OE_N (sramOeN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The model only drives the bus in the sampling cycles of a read, so any
    // other activity on the bus during a read must come from the controller.
    assign sramDq = modelOe ? sramMem[sramAddr] : 16'hzzzz;

    always @(posedge sramWeN) begin
        sramMem[sramAddr] <= sramDq;
    end

    function automatic logic dqFree(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Runs one full access starting at posedge+1 in IDLE: request cycle,
    // LOW0, LOW1, HIGH0, HIGH1, DONE; returns at posedge+1 of the next cycle.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [17:0] expLo, input logic [31:0] expRead,
                                 input bit hold);
        logic [17:0] expAddr;
        logic [15:0] expHalf;
        rdEn      = rd;
        wrEn      = wr;
        address   = addr;
        writeData = data;
        for (int c = 0; c < 6; c++) begin
            modelOe = rd && !wr && (c == 2 || c == 4);
            #4;
            checkOutput($sformatf("%s_c%0d_ready", tag, c), {31'b0, ready}, {31'b0, (c == 5)});
            checkOutput($sformatf("%s_c%0d_we_n", tag, c), {31'b0, sramWeN},
                        {31'b0, !(wr && (c == 1 || c == 3))});
            if (c >= 1 && c <= 4) begin
                expAddr = (c < 3) ? expLo : (expLo | 18'd1);
                checkOutput($sformatf("%s_c%0d_addr", tag, c), {14'b0, sramAddr}, {14'b0, expAddr});
            end
            if (wr && c >= 1 && c <= 4) begin
                expHalf = (c < 3) ? data[15:0] : data[31:16];
                checkOutput($sformatf("%s_c%0d_dq", tag, c), {16'b0, sramDq}, {16'b0, expHalf});
            end else if (!modelOe) begin
                checkOutput($sformatf("%s_c%0d_dq_free", tag, c), {31'b0, dqFree(sramDq)}, 32'd1);
            end
            if (c == 5) begin
                checkOutput($sformatf("%s_read_data", tag), readData, expRead);
            end
            @(posedge clk);
            #1;
            if (c == 0 && !hold) begin
                rdEn = 1'b0;
                wrEn = 1'b0;
            end
        end
        modelOe = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rstN       = 1'b0;
        rdEn       = 1'b0;
        wrEn       = 1'b0;
        address    = 32'h0;
        writeData  = 32'h0;
        modelOe    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'b0, ready}, 32'd1);
        checkOutput("reset_read_data", readData, 32'h0);
        checkOutput("reset_we_n", {31'b0, sramWeN}, 32'd1);
        checkOutput("reset_addr", {14'b0, sramAddr}, 32'h0);
        checkOutput("reset_dq_free", {31'b0, dqFree(sramDq)}, 32'd1);
        checkOutput("tied_strobes", {28'b0, sramUbN, sramLbN, sramCeN, sramOeN}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] write then read at base address");
        applyStimulus("wr_base", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'h0, 32'h0, 1'b0);
        checkOutput("mem0", {16'b0, sramMem[0]}, 32'h0000BEEF);
        checkOutput("mem1", {16'b0, sramMem[1]}, 32'h0000DEAD);
        applyStimulus("rd_base", 1'b1, 1'b0, 32'd1024, 32'hC3C35A5A, 18'h0, 32'hDEADBEEF, 1'b0);

        $display("[TB] address map and write after read");
        applyStimulus("wr_1032", 1'b0, 1'b1, 32'd1032, 32'h12345678, 18'h4, 32'hDEADBEEF, 1'b0);
        checkOutput("mem4", {16'b0, sramMem[4]}, 32'h00005678);
        checkOutput("mem5", {16'b0, sramMem[5]}, 32'h00001234);
        checkOutput("rd_kept_after_wr", readData, 32'hDEADBEEF);

        $display("[TB] idle window");
        for (int i = 0; i < 10; i++) begin
            #4;
            checkOutput($sformatf("idle%0d_ready", i), {31'b0, ready}, 32'd1);
            checkOutput($sformatf("idle%0d_we_n", i), {31'b0, sramWeN}, 32'd1);
            checkOutput($sformatf("idle%0d_dq_free", i), {31'b0, dqFree(sramDq)}, 32'd1);
            @(posedge clk);
            #1;
        end

        $display("[TB] simultaneous read and write");
        applyStimulus("rdwr_1040", 1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, 18'h8, 32'hDEADBEEF, 1'b0);
        checkOutput("mem8", {16'b0, sramMem[8]}, 32'h0000A5A5);
        checkOutput("mem9", {16'b0, sramMem[9]}, 32'h0000A5A5);
        applyStimulus("rd_1040", 1'b1, 1'b0, 32'd1040, 32'hC3C35A5A, 18'h8, 32'hA5A5A5A5, 1'b0);

        $display("[TB] address below base wraps");
        applyStimulus("wr_1020", 1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 18'h3FFFE, 32'hA5A5A5A5, 1'b0);
        checkOutput("mem_top_lo", {16'b0, sramMem[262142]}, 32'h0000F00D);
        checkOutput("mem_top_hi", {16'b0, sramMem[262143]}, 32'h00000BAD);

        $display("[TB] reset during a write");
        wrEn      = 1'b1;
        address   = 32'd1060;
        writeData = 32'h11112222;
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_addr", {14'b0, sramAddr}, 32'd18);
        checkOutput("pre_rst_ready", {31'b0, ready}, 32'd0);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_we_n", {31'b0, sramWeN}, 32'd1);
        checkOutput("mid_rst_read_data", readData, 32'h0);
        checkOutput("mid_rst_ready", {31'b0, ready}, 32'd1);
        checkOutput("mid_rst_addr", {14'b0, sramAddr}, 32'h0);
        checkOutput("mid_rst_dq_free", {31'b0, dqFree(sramDq)}, 32'd1);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("rd_after_rst", 1'b1, 1'b0, 32'd1032, 32'hC3C35A5A, 18'h4, 32'h12345678, 1'b0);

        $display("[TB] back-to-back held reads");
        applyStimulus("b2b_0", 1'b1, 1'b0, 32'd1024, 32'hC3C35A5A, 18'h0, 32'hDEADBEEF, 1'b1);
        applyStimulus("b2b_1", 1'b1, 1'b0, 32'd1024, 32'hC3C35A5A, 18'h0, 32'hDEADBEEF, 1'b1);
        applyStimulus("b2b_2", 1'b1, 1'b0, 32'd1024, 32'hC3C35A5A, 18'h0, 32'hDEADBEEF, 1'b0);
        #4;
        checkOutput("b2b_end_ready", {31'b0, ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
